muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one bit per cycle on operand magnitudes, with
// sign restoration in a fix-up cycle. Outputs are registered from the current state.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int AW = 2 * WIDTH + 1;
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q;
  logic             is_div_q;
  logic             neg_lo_q;
  logic             neg_hi_q;
  logic             zero_pend_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] opd_q;
  logic [AW-1:0]    acc_q;
  logic [WIDTH-1:0] res_hi_q;
  logic [WIDTH-1:0] res_lo_q;
  logic             res_dz_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             dz_q;

  logic             a_neg_s;
  logic             b_neg_s;
  logic [WIDTH-1:0] a_mag_s;
  logic [WIDTH-1:0] b_mag_s;
  logic             b_zero_s;
  logic [AW-1:0]    acc_d;
  logic [AW-1:0]    shl_s;
  logic [WIDTH:0]   trial_s;
  logic [WIDTH:0]   sum_s;
  logic [2*WIDTH-1:0] prod_fix_s;
  logic [WIDTH-1:0] quo_fix_s;
  logic [WIDTH-1:0] rem_fix_s;

  // Operand sign stripping at latch time
  always_comb begin
    a_neg_s  = op[0] & a[WIDTH-1];
    b_neg_s  = op[0] & b[WIDTH-1];
    if (a_neg_s) begin
      a_mag_s = {WIDTH{1'b0}} - a;
    end else begin
      a_mag_s = a;
    end
    if (b_neg_s) begin
      b_mag_s = {WIDTH{1'b0}} - b;
    end else begin
      b_mag_s = b;
    end
    b_zero_s = (b == {WIDTH{1'b0}});
  end

  // One iteration: shift-add (mul) or restoring shift-subtract (div)
  always_comb begin
    acc_d   = acc_q;
    shl_s   = {acc_q[AW-2:0], 1'b0};
    trial_s = shl_s[AW-1:WIDTH] - {1'b0, opd_q};
    sum_s   = {(WIDTH+1){1'b0}};
    if (is_div_q) begin
      if (!trial_s[WIDTH]) begin
        acc_d = {trial_s, shl_s[WIDTH-1:1], 1'b1};
      end else begin
        acc_d = shl_s;
      end
    end else begin
      if (acc_q[0]) begin
        sum_s = acc_q[AW-1:WIDTH] + {1'b0, opd_q};
      end else begin
        sum_s = acc_q[AW-1:WIDTH];
      end
      acc_d = {1'b0, sum_s, acc_q[WIDTH-1:1]};
    end
  end

  // Sign restoration of the finished magnitudes
  always_comb begin
    if (neg_lo_q) begin
      prod_fix_s = {(2*WIDTH){1'b0}} - acc_q[2*WIDTH-1:0];
      quo_fix_s  = {WIDTH{1'b0}} - acc_q[WIDTH-1:0];
    end else begin
      prod_fix_s = acc_q[2*WIDTH-1:0];
      quo_fix_s  = acc_q[WIDTH-1:0];
    end
    if (neg_hi_q) begin
      rem_fix_s = {WIDTH{1'b0}} - acc_q[2*WIDTH-1:WIDTH];
    end else begin
      rem_fix_s = acc_q[2*WIDTH-1:WIDTH];
    end
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      is_div_q    <= 1'b0;
      neg_lo_q    <= 1'b0;
      neg_hi_q    <= 1'b0;
      zero_pend_q <= 1'b0;
      cnt_q       <= {CW{1'b0}};
      opd_q       <= {WIDTH{1'b0}};
      acc_q       <= {AW{1'b0}};
      res_hi_q    <= {WIDTH{1'b0}};
      res_lo_q    <= {WIDTH{1'b0}};
      res_dz_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      hi_q        <= {WIDTH{1'b0}};
      lo_q        <= {WIDTH{1'b0}};
      dz_q        <= 1'b0;
    end else begin
      busy_q <= (state_q == CALC) || (state_q == FIX);
      done_q <= (state_q == DONE);
      if (state_q == DONE) begin
        hi_q <= res_hi_q;
        lo_q <= res_lo_q;
        dz_q <= res_dz_q;
      end
      case (state_q)
        IDLE: begin
          if (zero_pend_q) begin
            zero_pend_q <= 1'b0;
            state_q     <= DONE;
          end else if (start) begin
            is_div_q <= op[1];
            neg_lo_q <= a_neg_s ^ b_neg_s;
            neg_hi_q <= a_neg_s;
            cnt_q    <= {CW{1'b0}};
            if (op[1]) begin
              opd_q <= b_mag_s;
              acc_q <= {{(WIDTH+1){1'b0}}, a_mag_s};
            end else begin
              opd_q <= a_mag_s;
              acc_q <= {{(WIDTH+1){1'b0}}, b_mag_s};
            end
            // Divide by zero bypasses the iteration entirely
            if (op[1] && b_zero_s) begin
              res_hi_q    <= a;
              res_lo_q    <= {WIDTH{1'b1}};
              res_dz_q    <= 1'b1;
              zero_pend_q <= 1'b1;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST_ITER) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          if (is_div_q) begin
            res_lo_q <= quo_fix_s;
            res_hi_q <= rem_fix_s;
          end else begin
            res_hi_q <= prod_fix_s[2*WIDTH-1:WIDTH];
            res_lo_q <= prod_fix_s[WIDTH-1:0];
          end
          res_dz_q <= 1'b0;
          state_q  <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = dz_q;

endmodule
